mem_stage_sram_ctrl: RTL
========================

# mem_stage_sram_ctrl

Memory-stage responder for the load/store requests produced by the execute stage. It takes the execute stage's outputs: `mem_read`/`mem_write` strobes, the ALU result as byte address, and the forwarded Rm value as store data. It performs each 32-bit access as two sequential 16-bit accesses to an external SRAM with configurable access time. While an access is in progress it drops `ready`; the hazard/freeze logic stalls every upstream pipeline register on `~ready`.

## Interface
Parameters:
- `BASE_ADDR`, 1024: byte address that maps to SRAM halfword 0.
- `ACCESS_CYCLES`, 2: cycles each 16-bit SRAM phase is held (legal 1..15).
- `SRAM_ADDR_WIDTH`, 18: SRAM halfword address width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `mem_read` in 1: load request from execute/memory pipeline register.
- `mem_write` in 1: store request.
- `address` in `WORD_WIDTH` (32): byte address, i.e. ALU result.
- `write_data` in 32: store data, i.e. Rm value.
- `read_data` out 32: registered load result.
- `ready` out 1: 1 = no stall required this cycle.
- `sram_addr` out `SRAM_ADDR_WIDTH`: SRAM halfword address.
- `sram_wdata` out 16: SRAM write data.
- `sram_rdata` in 16: SRAM read data.
- `sram_we_n` out 1: SRAM write enable, active low.
- `sram_oe_n` out 1: SRAM output enable, active low.

## Operation
- FSM states: IDLE, LOW, HIGH, DONE. A phase counter counts 0..ACCESS_CYCLES-1.
- IDLE:
  - No request: `ready`=1, SRAM idle (we_n=oe_n=1).
  - `mem_read|mem_write`: `ready`=0. Latch op, address and write_data, then go to LOW with counter=0.
- Op decode: `mem_write` wins if both strobes are high. Both high is illegal upstream; the block handles it as a store.
- Address: eff = address − BASE_ADDR, modulo 2^32. Word index = eff[SRAM_ADDR_WIDTH:2].
  - LOW phase drives `sram_addr` = {word index, 1'b0}.
  - HIGH phase drives `sram_addr` = {word index, 1'b1}.
  - eff[1:0] is ignored. Out-of-range addresses wrap silently.
- LOW/HIGH:
  - Store: `sram_we_n`=0, `sram_wdata` = latched data [15:0] in LOW, [31:16] in HIGH.
  - Load: `sram_oe_n`=0. `sram_rdata` is sampled into read_data[15:0] (LOW) or [31:16] (HIGH) on the edge ending the phase's last cycle.
  - Phase ends when counter = ACCESS_CYCLES-1. LOW→HIGH, HIGH→DONE.
- DONE: `ready`=1 for exactly one cycle, SRAM idle, then go to IDLE unconditionally.
  - The pipeline advances on this edge, so the still-asserted strobe of the completed instruction is never re-accepted.
- `read_data` holds its value until the next load's halves overwrite it. Stores never modify it.
- SRAM outputs are driven only in LOW/HIGH. Otherwise `sram_addr`=0, `sram_wdata`=0, we_n=oe_n=1.

## Timing
- `ready` is combinational from state and strobes: 1 in IDLE without request, 1 in DONE, else 0.
- Request first seen at cycle 0 (IDLE). Timeline with A = ACCESS_CYCLES:
  - LOW occupies cycles 1..A.
  - HIGH occupies cycles A+1..2A.
  - DONE is cycle 2A+1.
- `ready` is low for 2A+1 cycles. Default A=2 gives 5 stall cycles, with `ready` high in cycle 5.
- Full load result is valid on `read_data` from cycle 2A+1 (DONE) onward.
- All other outputs are registered or state-decoded; no combinational path from `sram_rdata`.
- Reset values: state IDLE, counter 0, `read_data` 0, `sram_we_n`=`sram_oe_n`=1, `sram_addr`=0, `sram_wdata`=0. `ready` follows the IDLE rule.
- Reset mid-access aborts immediately and asynchronously. we_n/oe_n deassert in the same instant. A partially written word stays half-written; this is accepted.
- A strobe rising while in LOW/HIGH/DONE is ignored. The pipeline is frozen in LOW/HIGH, so this cannot occur legally.

## Structure
- `WORD_WIDTH` and `REG_FILE_DEPTH` come from the shared `constants.h`.
- Add `SRAM_DATA_WIDTH` (16) and the FSM state encodings (2-bit) to `constants.h`.
- One sub-module, `sram_phase_counter`: load/clear/terminal-count counter, reused for the LOW and HIGH phases.
- FSM, latches and read-data assembly live in the top module.

## Test plan
- Store 0xDEADBEEF to address 1024, A=2:
  - ready low cycles 0–4.
  - LOW: sram_addr=0, wdata=0xBEEF, we_n=0 for 2 cycles.
  - HIGH: sram_addr=1, wdata=0xDEAD.
  - ready=1 in cycle 5.
- Load from 1028 with an SRAM model holding 0x1234 at halfword 2 and 0xABCD at halfword 3: read_data=0xABCD1234 in DONE, and held through 3 idle cycles.
- Back-to-back store then load, strobes held high across DONE: each is accepted exactly once. Total stall 10 cycles, second access starts the cycle after DONE.
- Assert rst during HIGH of a store: we_n=1 and state IDLE immediately. After release, a new load completes normally; read_data was 0 after reset.
- mem_read and mem_write both high with A=1: handled as a store (we_n=0, oe_n=1). ready low for 3 cycles.
- Address 1023: eff=0xFFFFFFFF, which wraps to word index 0x1FFFF (all 1s). LOW drives sram_addr=0x3FFFE, HIGH 0x3FFFF.

Source files
------------

// File: rtl/mem_stage_sram_ctrl_pkg.sv
// Shared widths and FSM encoding for the memory-stage SRAM controller.
package mem_stage_sram_ctrl_pkg;
    localparam int WORD_WIDTH      = 32;
    localparam int REG_FILE_DEPTH  = 16;
    localparam int SRAM_DATA_WIDTH = 16;
    localparam int PHASE_CNT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } state_e;
endpackage

// File: rtl/mem_stage_sram_ctrl_phase_counter.sv
// Phase counter: counts 0..LAST while enabled, flags the last cycle, wraps to 0 on it.
// Clear forces 0 so each phase starts from a known count.
module sram_phase_counter
    import mem_stage_sram_ctrl_pkg::*;
#(
    parameter int LAST = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic tc
);
    localparam logic [PHASE_CNT_WIDTH-1:0] LAST_CNT = PHASE_CNT_WIDTH'(LAST);

    logic [PHASE_CNT_WIDTH-1:0] count_q, count_d;

    assign tc = en && (count_q == LAST_CNT);

    always_comb begin
        count_d = count_q;
        if (clear || tc) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// Memory-stage load/store responder: each 32-bit access becomes two 16-bit SRAM phases.
// ready drops for 2*ACCESS_CYCLES+1 cycles per access; upstream freezes on ~ready.
module mem_stage_sram_ctrl
    import mem_stage_sram_ctrl_pkg::*;
#(
    parameter logic [WORD_WIDTH-1:0] BASE_ADDR       = 32'd1024,
    parameter int                    ACCESS_CYCLES   = 2,
    parameter int                    SRAM_ADDR_WIDTH = 18
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mem_read,
    input  logic                       mem_write,
    input  logic [WORD_WIDTH-1:0]      address,
    input  logic [WORD_WIDTH-1:0]      write_data,
    output logic [WORD_WIDTH-1:0]      read_data,
    output logic                       ready,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
    output logic [SRAM_DATA_WIDTH-1:0] sram_wdata,
    input  logic [SRAM_DATA_WIDTH-1:0] sram_rdata,
    output logic                       sram_we_n,
    output logic                       sram_oe_n
);
    localparam int IDX_W = SRAM_ADDR_WIDTH - 1;

    state_e                     state_q, state_d;
    logic                       op_wr_q, op_wr_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [WORD_WIDTH-1:0]      wdata_q, wdata_d;
    logic [WORD_WIDTH-1:0]      read_data_q, read_data_d;
    logic [SRAM_ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;
    logic [SRAM_DATA_WIDTH-1:0] sram_wdata_q, sram_wdata_d;
    logic                       sram_we_n_q, sram_we_n_d;
    logic                       sram_oe_n_q, sram_oe_n_d;
    logic [WORD_WIDTH-1:0]      eff;
    logic                       req, in_phase, phase_tc;
    logic                       unused_eff_bits;

    assign req      = mem_read | mem_write;
    assign in_phase = (state_q == ST_LOW) || (state_q == ST_HIGH);
    assign eff      = address - BASE_ADDR;
    // Byte offset and bits above the SRAM window are dropped: out-of-range wraps.
    assign unused_eff_bits = ^{eff[WORD_WIDTH-1:SRAM_ADDR_WIDTH+1], eff[1:0]};

    assign ready      = ((state_q == ST_IDLE) && !req) || (state_q == ST_DONE);
    assign read_data  = read_data_q;
    assign sram_addr  = sram_addr_q;
    assign sram_wdata = sram_wdata_q;
    assign sram_we_n  = sram_we_n_q;
    assign sram_oe_n  = sram_oe_n_q;

    sram_phase_counter #(
        .LAST (ACCESS_CYCLES - 1)
    ) u_phase_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (!in_phase),
        .en    (in_phase),
        .tc    (phase_tc)
    );

    always_comb begin
        state_d     = state_q;
        op_wr_d     = op_wr_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        read_data_d = read_data_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_LOW;
                    op_wr_d = mem_write;
                    idx_d   = eff[SRAM_ADDR_WIDTH:2];
                    wdata_d = write_data;
                end
            end
            ST_LOW: begin
                if (phase_tc) begin
                    if (!op_wr_q) read_data_d[SRAM_DATA_WIDTH-1:0] = sram_rdata;
                    state_d = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (phase_tc) begin
                    if (!op_wr_q) read_data_d[WORD_WIDTH-1:SRAM_DATA_WIDTH] = sram_rdata;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // SRAM pins are registered from the next state so they align with the phase.
        sram_addr_d  = '0;
        sram_wdata_d = '0;
        sram_we_n_d  = 1'b1;
        sram_oe_n_d  = 1'b1;
        if ((state_d == ST_LOW) || (state_d == ST_HIGH)) begin
            sram_addr_d = {idx_d, state_d == ST_HIGH};
            sram_we_n_d = !op_wr_d;
            sram_oe_n_d = op_wr_d;
            if (op_wr_d) begin
                sram_wdata_d = (state_d == ST_HIGH) ? wdata_d[WORD_WIDTH-1:SRAM_DATA_WIDTH]
                                                    : wdata_d[SRAM_DATA_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            op_wr_q      <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= '0;
            read_data_q  <= '0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            sram_we_n_q  <= 1'b1;
            sram_oe_n_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            op_wr_q      <= op_wr_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            read_data_q  <= read_data_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            sram_we_n_q  <= sram_we_n_d;
            sram_oe_n_q  <= sram_oe_n_d;
        end
    end
endmodule
